// File: rtl/cart_cpu_bus_sequencer.sv
// Cartridge CPU-bus sequencer: free-running M2, one access per M2 period.
// Optional round-robin arbitration via ARB_ROUND_ROBIN_EN (else fixed prio).
// Ports: master_clock/nreset (sync, active-low); req/rw/addr/wdata and
//   done per requester (0 = FSMC bridge, 1 = burst/CRC engine); rdata, busy;
//   pin side m2, cpu_addr, cpu_rw, romsel, cpu_data_out/in, cpu_data_oe.
module cart_cpu_bus_sequencer #(
  parameter int M2_LOW_CYCLES  = 6,
  parameter int M2_HIGH_CYCLES = 6,
  parameter int ADDR_WIDTH     = 16
) (
  input  logic                  master_clock,
  input  logic                  nreset,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  rw0,
  input  logic                  rw1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [7:0]            wdata0,
  input  logic [7:0]            wdata1,
  output logic                  done0,
  output logic                  done1,
  output logic [7:0]            rdata,
  output logic                  busy,
  output logic                  m2,
  output logic [ADDR_WIDTH-1:0] cpu_addr,
  output logic                  cpu_rw,
  output logic                  romsel,
  output logic [7:0]            cpu_data_out,
  input  logic [7:0]            cpu_data_in,
  output logic                  cpu_data_oe
);

  localparam int P  = M2_LOW_CYCLES + M2_HIGH_CYCLES;
  localparam int PW = $clog2(P);
  localparam logic [PW-1:0] PH_LAST = PW'(P - 1);
  localparam logic [PW-1:0] PH_SAMP = PW'(P - 2);
  localparam logic [PW-1:0] PH_HI   = PW'(M2_LOW_CYCLES);

  typedef enum logic {IDLE, ACCESS} state_e;

  state_e                state_q, state_d;
  logic [PW-1:0]         ph_q, ph_d;
  logic                  gnt_q, gnt_d;
  logic                  m2_q, m2_d;
  logic                  romsel_q, romsel_d;
  logic                  rw_q, rw_d;
  logic                  oe_q, oe_d;
  logic                  busy_q, busy_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            dout_q, dout_d;
  logic [7:0]            rdata_q, rdata_d;
  logic                  done0_q, done0_d;
  logic                  done1_q, done1_d;

  logic arb_edge;
  logic grant_vld;
  logic grant_id;
  logic grant_rw;

`ifdef ARB_ROUND_ROBIN_EN
  // rr_q names the requester that wins the next conflict.
  logic rr_q, rr_d;
`endif

  assign arb_edge  = (ph_q == '0);
  assign grant_vld = req0 | req1;
  assign grant_rw  = grant_id ? rw1 : rw0;

`ifdef ARB_ROUND_ROBIN_EN
  assign grant_id = (req0 & req1) ? rr_q : req1;
`else
  assign grant_id = req1 & ~req0;
`endif

  always_ff @(posedge master_clock) begin
    if (!nreset) begin
      state_q  <= IDLE;
      ph_q     <= '0;
      gnt_q    <= 1'b0;
      m2_q     <= 1'b0;
      romsel_q <= 1'b1;
      rw_q     <= 1'b1;
      oe_q     <= 1'b0;
      busy_q   <= 1'b0;
      addr_q   <= '0;
      dout_q   <= '0;
      rdata_q  <= '0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      rr_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      ph_q     <= ph_d;
      gnt_q    <= gnt_d;
      m2_q     <= m2_d;
      romsel_q <= romsel_d;
      rw_q     <= rw_d;
      oe_q     <= oe_d;
      busy_q   <= busy_d;
      addr_q   <= addr_d;
      dout_q   <= dout_d;
      rdata_q  <= rdata_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
`ifdef ARB_ROUND_ROBIN_EN
      rr_q     <= rr_d;
`endif
    end
  end

  // State only moves at the edge ending ph0, so ACCESS covers ph1..ph0.
  always_comb begin
    ph_d    = (ph_q == PH_LAST) ? '0 : ph_q + PW'(1);
    state_d = state_q;
    gnt_d   = gnt_q;
`ifdef ARB_ROUND_ROBIN_EN
    rr_d    = rr_q;
`endif
    if (arb_edge) begin
      state_d = grant_vld ? ACCESS : IDLE;
      if (grant_vld) begin
        gnt_d = grant_id;
`ifdef ARB_ROUND_ROBIN_EN
        rr_d  = ~grant_id;
`endif
      end
    end
  end

  // Pin values hold through ph0 of the next period (hold after M2 fall)
  // and are only replaced at the arbitration edge.
  always_comb begin
    m2_d     = (ph_d >= PH_HI);
    romsel_d = 1'b1;
    rw_d     = rw_q;
    oe_d     = oe_q;
    busy_d   = busy_q;
    addr_d   = addr_q;
    dout_d   = dout_q;
    rdata_d  = rdata_q;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    if (arb_edge) begin
      if (grant_vld) begin
        addr_d = grant_id ? addr1 : addr0;
        rw_d   = grant_rw;
        oe_d   = ~grant_rw;
        busy_d = 1'b1;
        if (!grant_rw) dout_d = grant_id ? wdata1 : wdata0;
      end else begin
        rw_d   = 1'b1;
        oe_d   = 1'b0;
        busy_d = 1'b0;
      end
    end
    if (state_q == ACCESS) begin
      if (addr_q[ADDR_WIDTH-1] && (ph_d >= PH_HI)) romsel_d = 1'b0;
      if (ph_q == PH_SAMP) begin
        done0_d = ~gnt_q;
        done1_d = gnt_q;
        if (rw_q) rdata_d = cpu_data_in;
      end
    end
  end

  assign m2           = m2_q;
  assign romsel       = romsel_q;
  assign cpu_rw       = rw_q;
  assign cpu_data_oe  = oe_q;
  assign busy         = busy_q;
  assign cpu_addr     = addr_q;
  assign cpu_data_out = dout_q;
  assign rdata        = rdata_q;
  assign done0        = done0_q;
  assign done1        = done1_q;

endmodule

// File: tb/tb_cart_cpu_bus_sequencer.sv
// Bench for cart_cpu_bus_sequencer: period-level access model,
// directed scenarios plus randomized two-requester traffic.
module tb_cart_cpu_bus_sequencer;

  localparam int LOW = 6;
  localparam int HIGH = 6;
  localparam int P = LOW + HIGH;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic nreset = 1'b0;
  logic req [2];
  logic rw [2];
  logic [15:0] addr [2];
  logic [7:0] wd [2];
  logic [7:0] cpu_data_in = '0;
  logic done0, done1, busy, m2, cpu_rw, romsel, cpu_data_oe;
  logic [7:0] rdata, cpu_data_out;
  logic [15:0] cpu_addr;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cart_cpu_bus_sequencer #(
    .M2_LOW_CYCLES(LOW), .M2_HIGH_CYCLES(HIGH), .ADDR_WIDTH(16)
  ) dut (
    .master_clock(clk), .nreset(nreset),
    .req0(req[0]), .req1(req[1]), .rw0(rw[0]), .rw1(rw[1]),
    .addr0(addr[0]), .addr1(addr[1]),
    .wdata0(wd[0]), .wdata1(wd[1]),
    .done0(done0), .done1(done1), .rdata(rdata), .busy(busy),
    .m2(m2), .cpu_addr(cpu_addr), .cpu_rw(cpu_rw), .romsel(romsel),
    .cpu_data_out(cpu_data_out), .cpu_data_in(cpu_data_in),
    .cpu_data_oe(cpu_data_oe)
  );

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  // Model: phase of the current cycle and the access owning the bus.
  // The owner of period k stays on the pins through ph0 of period k+1.
  bit model_ok = 1'b0;
  int ph_m = 0;
  logic cur_v = 1'b0;
  logic cur_id = 1'b0;
  logic cur_rw = 1'b1;
  logic [15:0] cur_addr = '0;
  logic [15:0] hold_addr = '0;
  logic [7:0] hold_dout = '0;
  logic [7:0] rdata_m = '0;
  logic last_id = 1'b1;

  always @(posedge clk) begin
    if (!nreset) begin
      ph_m = 0; cur_v = 0; cur_rw = 1;
      hold_addr = '0; hold_dout = '0; rdata_m = '0;
      last_id = 1'b1; model_ok = 1'b1;
    end else begin
      if (ph_m == P - 2 && cur_v && cur_rw) rdata_m = cpu_data_in;
      if (ph_m == 0) begin
        cur_v = req[0] | req[1];
        if (cur_v) begin
          if (req[0] && req[1]) cur_id = RR ? ~last_id : 1'b0;
          else cur_id = req[1];
          last_id = cur_id;
          cur_rw = rw[cur_id];
          cur_addr = addr[cur_id];
          hold_addr = cur_addr;
          if (!cur_rw) hold_dout = wd[cur_id];
        end
      end
      ph_m = (ph_m + 1) % P;
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      chk("m2", m2, ph_m >= LOW);
      chk("romsel", romsel,
          !(cur_v && ph_m >= LOW && cur_addr[15]));
      chk("cpu_rw", cpu_rw, cur_v ? cur_rw : 1'b1);
      chk("cpu_data_oe", cpu_data_oe, cur_v && !cur_rw);
      chk("busy", busy, cur_v);
      chk("cpu_addr", cpu_addr, hold_addr);
      chk("cpu_data_out", cpu_data_out, hold_dout);
      chk("done0", done0, cur_v && !cur_id && ph_m == P - 1);
      chk("done1", done1, cur_v && cur_id && ph_m == P - 1);
      chk("rdata", rdata, rdata_m);
    end
  end

  task automatic wait_ph(input int k);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ph_m != k && n < 3 * P);
    chk("wait_ph", ph_m, k);
  endtask

  task automatic do_reset();
    @(negedge clk);
    nreset = 1'b0;
    req[0] = 1'b0; req[1] = 1'b0;
    repeat (2) @(negedge clk);
    nreset = 1'b1;
  endtask

  task automatic new_req(input int i);
    req[i] = 1'b1;
    rw[i] = 1'($urandom);
    addr[i] = 16'($urandom);
    wd[i] = 8'($urandom);
  endtask

  int cnt;
  int viol;
  int log_q [$];
  int exp_c [4];
  int r;

  initial begin
    for (int i = 0; i < 2; i++) begin
      req[i] = 0; rw[i] = 1; addr[i] = '0; wd[i] = '0;
    end
    do_reset();
    chk("rst_m2", m2, 0);
    chk("rst_romsel", romsel, 1);
    chk("rst_busy", busy, 0);
    chk("rst_addr", cpu_addr, 0);

    // single read, then back-to-back read
    req[0] = 1; rw[0] = 1; addr[0] = 16'h8000; cpu_data_in = 8'h5A;
    wait_ph(1);
    chk("rd_addr", cpu_addr, 16'h8000);
    chk("rd_busy", busy, 1);
    wait_ph(6);
    chk("rd_romsel", romsel, 0);
    wait_ph(10);
    chk("rd_done_early", done0, 0);
    wait_ph(11);
    chk("rd_done", done0, 1);
    chk("rd_rdata", rdata, 8'h5A);
    addr[0] = 16'h8001; cpu_data_in = 8'hA5;
    wait_ph(0);
    chk("rd_hold_addr", cpu_addr, 16'h8000);
    chk("rd_hold_busy", busy, 1);
    chk("rd_ph0_romsel", romsel, 1);
    @(negedge clk);
    chk("b2b_addr", cpu_addr, 16'h8001);
    cnt = 0;
    for (int i = 0; i < P; i++) begin
      @(negedge clk);
      if (m2) cnt++;
    end
    chk("b2b_m2_high", cnt, HIGH);
    wait_ph(11);
    chk("b2b_done", done0, 1);
    chk("b2b_rdata", rdata, 8'hA5);
    req[0] = 0;
    wait_ph(1);
    chk("idle_busy", busy, 0);
    chk("idle_addr", cpu_addr, 16'h8001);

    // single write
    req[1] = 1; rw[1] = 0; addr[1] = 16'h6000; wd[1] = 8'hC3;
    wait_ph(1);
    chk("wr_rw", cpu_rw, 0);
    chk("wr_oe", cpu_data_oe, 1);
    chk("wr_dout", cpu_data_out, 8'hC3);
    wait_ph(6);
    chk("wr_romsel", romsel, 1);
    wait_ph(11);
    chk("wr_done", done1, 1);
    chk("wr_rdata_hold", rdata, 8'hA5);
    req[1] = 0;
    wait_ph(0);
    chk("wr_hold_oe", cpu_data_oe, 1);
    wait_ph(1);
    chk("wr_idle_oe", cpu_data_oe, 0);

    // reset in the middle of a write
    req[1] = 1; wd[1] = 8'h3C;
    wait_ph(1);
    wait_ph(5);
    nreset = 0;
    @(negedge clk);
    chk("mr_m2", m2, 0);
    chk("mr_romsel", romsel, 1);
    chk("mr_rw", cpu_rw, 1);
    chk("mr_oe", cpu_data_oe, 0);
    chk("mr_busy", busy, 0);
    req[1] = 0; nreset = 1;
    cnt = 0;
    for (int i = 0; i < 2 * P; i++) begin
      @(negedge clk);
      if (done1) cnt++;
    end
    chk("mr_no_done", cnt, 0);

    // conflict with both requests held
    do_reset();
    req[0] = 1; rw[0] = 1; addr[0] = 16'h8100;
    req[1] = 1; rw[1] = 1; addr[1] = 16'h0200;
    for (int i = 0; i < 4 * P; i++) begin
      @(negedge clk);
      if (done0) log_q.push_back(0);
      if (done1) log_q.push_back(1);
    end
    req[0] = 0; req[1] = 0;
    if (RR) exp_c = '{0, 1, 0, 1};
    else exp_c = '{0, 0, 0, 0};
    chk("conf_count", log_q.size(), 4);
    for (int i = 0; i < 4; i++)
      chk("conf_grant", (i < log_q.size()) ? log_q[i] : 9, exp_c[i]);

    // idle M2 for 100 periods
    wait_ph(1);
    wait_ph(1);
    cnt = 0; viol = 0;
    for (int i = 0; i < 100 * P; i++) begin
      @(negedge clk);
      if (m2) cnt++;
      if (!romsel || !cpu_rw || busy) viol++;
    end
    chk("idle_m2_high", cnt, 100 * HIGH);
    chk("idle_viol", viol, 0);

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      cpu_data_in = 8'($urandom);
      for (int i = 0; i < 2; i++) begin
        if (cur_v && cur_id == 1'(i) && ph_m >= 1 && ph_m <= P - 2)
          continue;
        r = $urandom_range(99);
        if (req[i]) begin
          if (cur_v && cur_id == 1'(i) && ph_m == P - 1) begin
            if (r < 60) new_req(i);
            else req[i] = 0;
          end else if (r < 8) req[i] = 0;
          else if (r < 16) new_req(i);
        end else if (r < 30) new_req(i);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
